fifo_burst_reader: RTL and testbench
====================================

Name: fifo_burst_reader

Overview:
Read-side controller for the team's FIFO. It runs in the FIFO read clock domain. On a start command it drains a programmed number of words from the FIFO read port. It never issues a read when the FIFO is empty, so FIFO underflow cannot occur. Words are delivered on a valid/ready output stream through a 2-entry skid buffer, and the block reports progress and completion.

Parameters:
WIDTH, 8, data word width; must match the FIFO WIDTH
MAX_LEN, 256, largest transfer length in words
LEN_WIDTH, $clog2(MAX_LEN)+1, width of the length and count fields

Ports:
clk  input  1  clock; the same clock as the FIFO rd_clk
res  input  1  synchronous, active-high reset
start  input  1  transfer request; accepted only in IDLE
len  input  LEN_WIDTH  number of words to read; sampled on an accepted start
fifo_empty  input  1  FIFO empty flag
fifo_rdata  input  WIDTH  FIFO read data; registered by the FIFO, valid the cycle after fifo_rd_en
fifo_rd_en  output  1  FIFO read strobe
out_valid  output  1  out_data holds a word
out_data  output  WIDTH  head word of the skid buffer
out_ready  input  1  downstream accepts the word
busy  output  1  state is not IDLE
done  output  1  one-cycle pulse when a transfer completes
words_out  output  LEN_WIDTH  handshakes completed in the current or last transfer
start_err  output  1  one-cycle pulse: start arrived while busy

Behaviour:
- Reset is synchronous on res=1 at a clk edge:
  - state goes to IDLE; rem, inflight, occ and words_out are set to 0.
  - The skid buffer is cleared, so out_data=0.
  - out_valid, done, start_err and busy are 0.
- fifo_rd_en is forced to 0 while res=1. Reset mid-transfer discards buffered and in-flight words, and no done pulse is produced.
- Internal state:
  - rem (LEN_WIDTH bits): reads still to issue.
  - inflight (1 bit): a read was issued last cycle.
  - occ (0..2): skid-buffer occupancy.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - start=1 with len!=0 → RUN; rem<=len, words_out<=0.
  - start=1 with len==0 → DONE; words_out<=0.
- RUN:
  - fifo_rd_en = !fifo_empty && rem!=0 && (occ + inflight − pop) <= 1, where pop = out_valid && out_ready.
  - fifo_rd_en is combinational, from registered state plus fifo_empty and out_ready. The same-cycle pop credit allows one read per cycle when downstream is always ready.
  - Each fifo_rd_en decrements rem and sets inflight for the next cycle.
  - When rem becomes 0 → FLUSH.
- FLUSH: no reads are issued. When inflight==0 and occ==0 → DONE.
- DONE: done=1 for exactly one cycle, then → IDLE.
- Data path:
  - The word from a read in cycle N appears on fifo_rdata in cycle N+1 and is written into the skid buffer at the end of N+1.
  - out_valid=1 from cycle N+2, so latency is 2 cycles from rd_en to out_valid.
  - The buffer is FIFO-ordered. Simultaneous write and pop are allowed and occ is unchanged.
  - The buffer never overflows: the issue rule guarantees occ + inflight <= 2.
- Stream rules:
  - out_valid = (occ!=0).
  - While out_valid=1 and out_ready=0, out_data is held stable.
  - out_valid never drops without a handshake.
- words_out increments on each handshake and holds its value after DONE until the next accepted start.
- start in any state other than IDLE is ignored: no state change, len is not sampled, and start_err pulses for one cycle, the cycle after.
- fifo_rd_en is never asserted while fifo_empty=1. An empty FIFO mid-RUN stalls reads, and reads resume in the first cycle fifo_empty=0.
- Every output is registered except fifo_rd_en.

Test Plan:
1. FIFO preloaded 0x11,0x22,0x33,0x44; out_ready=1; start in cycle 0 with len=4.
   → fifo_rd_en high in cycles 1–4.
   → out_valid high in cycles 3–6 with data 0x11,0x22,0x33,0x44.
   → done=1 in cycle 8 only; words_out=4; busy=0 from cycle 9.
2. Preloaded 6 words, len=6, out_ready=0.
   → exactly 2 fifo_rd_en, then none; out_data=first word, stable.
   → release out_ready → remaining 4 words read and delivered in order; words_out=6.
3. FIFO empty at start, len=3; push one word every 5 cycles.
   → fifo_rd_en only in cycles with fifo_empty=0; 3 words delivered in order; FIFO underflow never set.
4. start with len=0 in cycle 0 → done=1 in cycle 1; fifo_rd_en never asserted; words_out=0.
5. start with len=8, then another start with len=2 at cycle 3.
   → start_err=1 in cycle 4 only; the transfer completes with words_out=8.
6. res=1 asserted in cycle 4 of a len=8 transfer.
   → at cycle 5: state IDLE, out_valid=0, busy=0, words_out=0, no done.
   → a fresh start with len=2 then works normally.

Source files
------------

// File: rtl/fifo_burst_reader.sv
// Burst read controller for the FIFO read port: drains a programmed number of
// words, never reads an empty FIFO, and streams them through a 2-entry skid buffer.
module fifo_burst_reader #(
    parameter int WIDTH     = 8,
    parameter int MAX_LEN   = 256,
    parameter int LEN_WIDTH = $clog2(MAX_LEN) + 1
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] len,
    input  logic                 fifo_empty,
    input  logic [WIDTH-1:0]     fifo_rdata,
    output logic                 fifo_rd_en,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done,
    output logic [LEN_WIDTH-1:0] words_out,
    output logic                 start_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                   state_reg, state_next;
    logic [LEN_WIDTH-1:0]     rem_reg, rem_next;
    logic [LEN_WIDTH-1:0]     words_reg, words_next;
    logic                     inflight_reg;
    logic [1:0]               occ_reg, occ_next, wr_pos;
    logic [2:0]               level;
    logic [1:0][WIDTH-1:0]    mem_reg, mem_next;
    logic                     valid_reg, busy_reg, done_reg, start_err_reg;
    logic                     busy_next, done_next, start_err_next;
    logic                     pop, rd_en, accept;

    assign pop    = valid_reg && out_ready;
    // Occupancy after this cycle's pop plus the word already in flight; a new
    // read is only allowed when that leaves room for it.
    assign level  = {1'b0, occ_reg} + {2'b00, inflight_reg} - {2'b00, pop};
    assign occ_next = level[1:0];
    assign wr_pos = occ_reg - {1'b0, pop};
    assign accept = (state_reg == IDLE) && start;

    always_ff @(posedge clk) begin
        if (res) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        rem_next   = rem_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_next = RUN;
                        rem_next   = len;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            RUN: begin
                if (rd_en) begin
                    rem_next = rem_reg - LEN_WIDTH'(1);
                    if (rem_reg == LEN_WIDTH'(1)) begin
                        state_next = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (!inflight_reg && occ_reg == 2'd0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        rd_en = !res && (state_reg == RUN) && !fifo_empty
                && (rem_reg != '0) && (level <= 3'd1);
        busy_next      = (state_next != IDLE);
        done_next      = (state_next == DONE);
        start_err_next = start && (state_reg != IDLE);
        words_next     = words_reg;
        if (accept) begin
            words_next = '0;
        end else if (pop) begin
            words_next = words_reg + LEN_WIDTH'(1);
        end
    end

    // Entry 0 is the head; a pop shifts entry 1 down, and the arriving word
    // lands in the first free slot after that shift.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_skid
            localparam int SRC = (gi == 0) ? 1 : gi;
            assign mem_next[gi] = (inflight_reg && wr_pos == 2'(gi)) ? fifo_rdata :
                                  pop                                 ? mem_reg[SRC] :
                                                                        mem_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (res) begin
            rem_reg       <= '0;
            inflight_reg  <= 1'b0;
            occ_reg       <= 2'd0;
            valid_reg     <= 1'b0;
            words_reg     <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            start_err_reg <= 1'b0;
            mem_reg       <= '0;
        end else begin
            rem_reg       <= rem_next;
            inflight_reg  <= rd_en;
            occ_reg       <= occ_next;
            valid_reg     <= (occ_next != 2'd0);
            words_reg     <= words_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            start_err_reg <= start_err_next;
            mem_reg       <= mem_next;
        end
    end

    assign fifo_rd_en = rd_en;
    assign out_valid  = valid_reg;
    assign out_data   = mem_reg[0];
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign words_out  = words_reg;
    assign start_err  = start_err_reg;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural FIFO read port
// (registered read data, empty flag updated at the clock edge).
module tb_fifo_burst_reader;

    localparam int WIDTH = 8;
    localparam int LW    = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             res = 1'b1;
    logic             start = 1'b0;
    logic [LW-1:0]    len = '0;
    logic             fifo_empty = 1'b1;
    logic [WIDTH-1:0] fifo_rdata = '0;
    logic             out_ready = 1'b0;
    logic             fifo_rd_en, out_valid, busy, done, start_err;
    logic [WIDTH-1:0] out_data;
    logic [LW-1:0]    words_out;

    logic             push_req = 1'b0;
    logic [7:0]       push_data = '0;
    logic [7:0]       fifo_q[$];
    bit               underflow = 1'b0;

    int checks = 0;
    int errors = 0;

    fifo_burst_reader #(.WIDTH(WIDTH), .MAX_LEN(256), .LEN_WIDTH(LW)) dut (
        .clk(clk), .res(res), .start(start), .len(len),
        .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_rd_en(fifo_rd_en),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .done(done), .words_out(words_out), .start_err(start_err)
    );

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (fifo_q.size() == 0) underflow <= 1'b1;
            else fifo_rdata <= fifo_q.pop_front();
        end
        if (push_req) fifo_q.push_back(push_data);
        fifo_empty <= (fifo_q.size() == 0);
    end

    always @(posedge clk) begin
        if (!res && out_valid && out_ready)
            $display("xfer data=%02h words_out=%0d", out_data, words_out);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic push_seq(input logic [7:0] base, input logic [7:0] step, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            push_req  = 1'b1;
            push_data = base + 8'(i) * step;
        end
        @(negedge clk);
        push_req = 1'b0;
    endtask

    task automatic test_reset();
        res = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (start_err !== 1'b0) begin errors++; $display("FAIL reset_start_err got %b want 0", start_err); end
        checks++; if (words_out !== '0) begin errors++; $display("FAIL reset_words got %0d want 0", words_out); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %02h want 00", out_data); end
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", fifo_rd_en); end
        @(negedge clk);
        res = 1'b0;
    endtask

    task automatic test_basic();
        logic exp_rd, exp_v, exp_done, exp_busy;
        logic [7:0] exp_d;
        push_seq(8'h11, 8'h11, 4);
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            start = (c == 0);
            len   = 9'd4;
            #1;
            exp_rd   = (c >= 1 && c <= 4);
            exp_v    = (c >= 3 && c <= 6);
            exp_done = (c == 8);
            exp_busy = (c >= 1 && c <= 8);
            exp_d    = 8'(17 * (c - 2));
            checks++; if (fifo_rd_en !== exp_rd) begin errors++; $display("FAIL basic_rd_en c=%0d got %b want %b", c, fifo_rd_en, exp_rd); end
            checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL basic_valid c=%0d got %b want %b", c, out_valid, exp_v); end
            if (exp_v) begin
                checks++; if (out_data !== exp_d) begin errors++; $display("FAIL basic_data c=%0d got %02h want %02h", c, out_data, exp_d); end
            end
            checks++; if (done !== exp_done) begin errors++; $display("FAIL basic_done c=%0d got %b want %b", c, done, exp_done); end
            checks++; if (busy !== exp_busy) begin errors++; $display("FAIL basic_busy c=%0d got %b want %b", c, busy, exp_busy); end
        end
        checks++; if (words_out !== 9'd4) begin errors++; $display("FAIL basic_words got %0d want 4", words_out); end
    endtask

    task automatic test_backpressure();
        int rd_cnt = 0;
        bit seen_done = 1'b0;
        logic [7:0] got[$];
        push_seq(8'hB0, 8'h01, 6);
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            start = (c == 0);
            len   = 9'd6;
            #1;
            if (fifo_rd_en) rd_cnt++;
            if (c >= 3) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid c=%0d got %b want 1", c, out_valid); end
                checks++; if (out_data !== 8'hB0) begin errors++; $display("FAIL bp_hold c=%0d got %02h want b0", c, out_data); end
            end
        end
        checks++; if (rd_cnt != 2) begin errors++; $display("FAIL bp_rd_count got %0d want 2", rd_cnt); end
        for (int c = 0; c < 40 && !seen_done; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            #1;
            if (out_valid) got.push_back(out_data);
            if (done) seen_done = 1'b1;
        end
        checks++; if (!seen_done) begin errors++; $display("FAIL bp_done got 0 want 1"); end
        checks++; if (got.size() != 6) begin errors++; $display("FAIL bp_count got %0d want 6", got.size()); end
        for (int i = 0; i < got.size() && i < 6; i++) begin
            checks++; if (got[i] !== 8'hB0 + 8'(i)) begin errors++; $display("FAIL bp_order i=%0d got %02h want %02h", i, got[i], 8'hB0 + 8'(i)); end
        end
        checks++; if (words_out !== 9'd6) begin errors++; $display("FAIL bp_words got %0d want 6", words_out); end
    endtask

    task automatic test_empty_stall();
        int viol = 0, pushed = 0, rd_cnt = 0;
        bit seen_done = 1'b0;
        logic [7:0] got[$];
        out_ready = 1'b1;
        for (int c = 0; c < 60 && !seen_done; c++) begin
            @(negedge clk);
            start    = (c == 0);
            len      = 9'd3;
            push_req = (c % 5 == 0) && (pushed < 3);
            if (push_req) begin
                push_data = 8'hC0 + 8'(pushed);
                pushed++;
            end
            #1;
            if (fifo_rd_en && fifo_empty) viol++;
            if (fifo_rd_en) rd_cnt++;
            if (out_valid) got.push_back(out_data);
            if (done) seen_done = 1'b1;
        end
        @(negedge clk);
        push_req = 1'b0;
        checks++; if (viol != 0) begin errors++; $display("FAIL empty_rd_when_empty got %0d want 0", viol); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL empty_underflow got %b want 0", underflow); end
        checks++; if (rd_cnt != 3) begin errors++; $display("FAIL empty_rd_count got %0d want 3", rd_cnt); end
        checks++; if (!seen_done) begin errors++; $display("FAIL empty_done got 0 want 1"); end
        checks++; if (got.size() != 3) begin errors++; $display("FAIL empty_count got %0d want 3", got.size()); end
        for (int i = 0; i < got.size() && i < 3; i++) begin
            checks++; if (got[i] !== 8'hC0 + 8'(i)) begin errors++; $display("FAIL empty_order i=%0d got %02h want %02h", i, got[i], 8'hC0 + 8'(i)); end
        end
        checks++; if (words_out !== 9'd3) begin errors++; $display("FAIL empty_words got %0d want 3", words_out); end
    endtask

    task automatic test_zero_len();
        logic exp_done;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            start = (c == 0);
            len   = 9'd0;
            #1;
            exp_done = (c == 1);
            checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL zero_rd_en c=%0d got %b want 0", c, fifo_rd_en); end
            checks++; if (done !== exp_done) begin errors++; $display("FAIL zero_done c=%0d got %b want %b", c, done, exp_done); end
            if (c >= 1) begin
                checks++; if (words_out !== 9'd0) begin errors++; $display("FAIL zero_words c=%0d got %0d want 0", c, words_out); end
            end
        end
    endtask

    task automatic test_start_err();
        bit seen_done = 1'b0;
        logic exp_err;
        logic [7:0] got[$];
        push_seq(8'hD0, 8'h01, 8);
        out_ready = 1'b1;
        for (int c = 0; c < 60 && !seen_done; c++) begin
            @(negedge clk);
            start = (c == 0) || (c == 3);
            len   = (c == 3) ? 9'd2 : 9'd8;
            #1;
            exp_err = (c == 4);
            checks++; if (start_err !== exp_err) begin errors++; $display("FAIL serr_pulse c=%0d got %b want %b", c, start_err, exp_err); end
            if (out_valid) got.push_back(out_data);
            if (done) seen_done = 1'b1;
        end
        checks++; if (!seen_done) begin errors++; $display("FAIL serr_done got 0 want 1"); end
        checks++; if (got.size() != 8) begin errors++; $display("FAIL serr_count got %0d want 8", got.size()); end
        for (int i = 0; i < got.size() && i < 8; i++) begin
            checks++; if (got[i] !== 8'hD0 + 8'(i)) begin errors++; $display("FAIL serr_order i=%0d got %02h want %02h", i, got[i], 8'hD0 + 8'(i)); end
        end
        checks++; if (words_out !== 9'd8) begin errors++; $display("FAIL serr_words got %0d want 8", words_out); end
    endtask

    task automatic test_reset_mid();
        bit seen_done = 1'b0;
        logic [7:0] got[$];
        push_seq(8'hA0, 8'h01, 8);
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            start = (c == 0);
            len   = 9'd8;
            res   = (c == 4);
            #1;
            if (c == 4) begin
                checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en got %b want 0", fifo_rd_en); end
            end
        end
        for (int c = 5; c < 9; c++) begin
            @(negedge clk);
            res = 1'b0;
            #1;
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_no_done c=%0d got %b want 0", c, done); end
            if (c == 5) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", out_valid); end
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
                checks++; if (words_out !== 9'd0) begin errors++; $display("FAIL rst_words got %0d want 0", words_out); end
            end
        end
        for (int c = 0; c < 30 && !seen_done; c++) begin
            @(negedge clk);
            start = (c == 0);
            len   = 9'd2;
            #1;
            if (out_valid) got.push_back(out_data);
            if (done) seen_done = 1'b1;
        end
        checks++; if (!seen_done) begin errors++; $display("FAIL rst_restart_done got 0 want 1"); end
        checks++; if (got.size() != 2) begin errors++; $display("FAIL rst_restart_count got %0d want 2", got.size()); end
        for (int i = 0; i < got.size() && i < 2; i++) begin
            checks++; if (got[i] !== 8'hA3 + 8'(i)) begin errors++; $display("FAIL rst_restart_order i=%0d got %02h want %02h", i, got[i], 8'hA3 + 8'(i)); end
        end
        checks++; if (words_out !== 9'd2) begin errors++; $display("FAIL rst_restart_words got %0d want 2", words_out); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_empty_stall();
        test_zero_len();
        test_start_err();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
